// File: rtl/wb_host_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_host_master_pkg
// Brief    : Shared FSM encoding, default parameters and helpers for the
//            Wishbone host master.
// Revision : 1.0 - initial release
// ============================================================================
package wb_host_master_pkg;

    localparam int C_DEFAULT_DW      = 32;
    localparam int C_DEFAULT_AW      = 32;
    localparam int C_DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter width able to hold TIMEOUT-1; never narrower than one bit.
    function automatic int timer_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_host_master_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_host_master_if
// Brief    : Command/response handshake plus Wishbone classic master bus.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_host_master_if
    import wb_host_master_pkg::*;
#(
    parameter int DW = C_DEFAULT_DW,
    parameter int AW = C_DEFAULT_AW
);

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_we_i;
    logic [AW-1:0]     cmd_adr_i;
    logic [DW-1:0]     cmd_dat_i;
    logic [DW/8-1:0]   cmd_sel_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DW-1:0]     rsp_dat_o;
    logic              rsp_err_o;

    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [AW-1:0]     wbm_adr_o;
    logic [DW-1:0]     wbm_dat_o;
    logic [DW/8-1:0]   wbm_sel_o;
    logic [DW-1:0]     wbm_dat_i;
    logic              wbm_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  rsp_ready_i, wbm_dat_i, wbm_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output rsp_ready_i, wbm_dat_i, wbm_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

endinterface
`default_nettype wire

// File: rtl/wb_host_master_timer.sv
`default_nettype none
// ============================================================================
// Module   : wb_host_master_timer
// Brief    : Counts bus cycles; expired flags the TIMEOUT-th cycle.
// Revision : 1.0 - initial release
// ============================================================================
module wb_host_master_timer
    import wb_host_master_pkg::*;
#(
    parameter int TIMEOUT = C_DEFAULT_TIMEOUT
)(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    localparam int C_CW = timer_width(TIMEOUT);

    logic [C_CW-1:0] r_count;

    // Saturates at the terminal value so a stalled enable cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == C_CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/wb_host_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_host_master
// Brief    : Single-transfer Wishbone classic host master; optional bus
//            timeout enabled by WB_HOST_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_host_master
    import wb_host_master_pkg::*;
#(
    parameter int DW      = C_DEFAULT_DW,
    parameter int AW      = C_DEFAULT_AW,
    parameter int TIMEOUT = C_DEFAULT_TIMEOUT
)(
    input  wire logic        wb_clk_i,
    input  wire logic        wb_rst_i,
    wb_host_master_if.master wbif,
    output logic             busy_o
);

    localparam int C_SW = DW / 8;

    if ((DW % 8) != 0 || DW < 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("wb_host_master: illegal DW or TIMEOUT parameter");
    end

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_cyc;
    logic            r_we;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_dat;
    logic [C_SW-1:0] r_sel;
    logic [DW-1:0]   r_rsp_dat;

    logic            w_ready;
    logic            w_accept;
    logic            w_in_bus;
    logic            w_ack;
    logic            w_timeout;
    logic            w_done;
    logic            w_rsp_take;

    // Ready is masked by reset so it stays low for the whole reset pulse.
    assign w_ready    = (r_state == IDLE) && !wb_rst_i;
    assign w_accept   = w_ready && wbif.cmd_valid_i;
    assign w_in_bus   = (r_state == BUS);
    assign w_ack      = w_in_bus && wbif.wbm_ack_i;
    assign w_done     = w_ack || w_timeout;
    assign w_rsp_take = (r_state == RESP) && wbif.rsp_ready_i;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
    logic w_expired;
    logic r_rsp_err;

    wb_host_master_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (w_accept),
        .enable  (w_in_bus),
        .expired (w_expired)
    );

    // A coincident ack takes priority over the timeout.
    assign w_timeout = w_in_bus && w_expired && !wbif.wbm_ack_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rsp_err <= 1'b0;
        end else if (w_done) begin
            r_rsp_err <= w_timeout;
        end else if (w_rsp_take) begin
            r_rsp_err <= 1'b0;
        end
    end

    assign wbif.rsp_err_o = r_rsp_err;
`else
    assign w_timeout      = 1'b0;
    assign wbif.rsp_err_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = BUS;
            BUS:     if (w_done)     w_state_nxt = RESP;
            RESP:    if (w_rsp_take) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    // Bus outputs return to zero whenever the cycle is not active.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_rsp_dat <= '0;
        end else if (w_accept) begin
            r_cyc     <= 1'b1;
            r_we      <= wbif.cmd_we_i;
            r_adr     <= wbif.cmd_adr_i;
            r_dat     <= wbif.cmd_dat_i;
            r_sel     <= wbif.cmd_sel_i;
        end else if (w_done) begin
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_rsp_dat <= (w_ack && !r_we) ? wbif.wbm_dat_i : '0;
        end else if (w_rsp_take) begin
            r_rsp_dat <= '0;
        end
    end

    assign wbif.cmd_ready_o = w_ready;
    assign wbif.rsp_valid_o = (r_state == RESP);
    assign wbif.rsp_dat_o   = r_rsp_dat;
    assign wbif.wbm_cyc_o   = r_cyc;
    assign wbif.wbm_stb_o   = r_cyc;
    assign wbif.wbm_we_o    = r_we;
    assign wbif.wbm_adr_o   = r_adr;
    assign wbif.wbm_dat_o   = r_dat;
    assign wbif.wbm_sel_o   = r_sel;
    assign busy_o           = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wb_host_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_host_master
// Brief    : Self-checking bench for wb_host_master (table, random, corners).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_host_master;

    localparam int TO = 4;

    logic clk;
    logic rst;
    logic busy;
    int   n_cmp;
    int   n_err;

    wb_host_master_if #(.DW(32), .AW(32)) wbif ();

    wb_host_master #(
        .DW      (32),
        .AW      (32),
        .TIMEOUT (TO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbif     (wbif),
        .busy_o   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ack_dly;
        int          rsp_wait;
        logic [31:0] rdata;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Runs one command end to end; called and returns at a falling edge.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int ack_dly, input int rsp_wait,
                           input logic [31:0] rdata, input logic [31:0] exp_dat,
                           input logic exp_err, input int exp_cyc, input logic hold,
                           input string tag);
        wbif.cmd_we_i    = we;
        wbif.cmd_adr_i   = adr;
        wbif.cmd_dat_i   = dat;
        wbif.cmd_sel_i   = sel;
        wbif.cmd_valid_i = 1'b1;
        chk({tag, " cmd_ready idle"}, 64'(wbif.cmd_ready_o), 64'd1);
        @(posedge clk);
        @(negedge clk);
        wbif.cmd_valid_i = hold;
        for (int k = 1; k <= exp_cyc; k++) begin
            chk({tag, " cyc/stb"}, 64'({wbif.wbm_cyc_o, wbif.wbm_stb_o}), 64'b11);
            chk({tag, " we"},  64'(wbif.wbm_we_o),  64'(we));
            chk({tag, " adr"}, 64'(wbif.wbm_adr_o), 64'(adr));
            chk({tag, " dat"}, 64'(wbif.wbm_dat_o), 64'(dat));
            chk({tag, " sel"}, 64'(wbif.wbm_sel_o), 64'(sel));
            chk({tag, " bus ready/busy/rsp"},
                64'({wbif.cmd_ready_o, busy, wbif.rsp_valid_o}), 64'b010);
            wbif.wbm_ack_i = (k == ack_dly + 1);
            wbif.wbm_dat_i = (k == ack_dly + 1) ? rdata : 32'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        wbif.wbm_ack_i = 1'b0;
        chk({tag, " cyc/stb dropped"}, 64'({wbif.wbm_cyc_o, wbif.wbm_stb_o}), 64'b00);
        chk({tag, " idle bus zero"},
            64'({wbif.wbm_we_o, wbif.wbm_sel_o, wbif.wbm_dat_o}), 64'd0);
        chk({tag, " rsp_valid"}, 64'(wbif.rsp_valid_o), 64'd1);
        chk({tag, " rsp_dat"},   64'(wbif.rsp_dat_o),   64'(exp_dat));
        chk({tag, " rsp_err"},   64'(wbif.rsp_err_o),   64'(exp_err));
        chk({tag, " resp ready/busy"}, 64'({wbif.cmd_ready_o, busy}), 64'b01);
        for (int w = 0; w < rsp_wait; w++) begin
            wbif.wbm_ack_i = 1'($urandom_range(0, 1));
            wbif.wbm_dat_i = 32'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, " rsp held"},
                64'({wbif.rsp_valid_o, wbif.rsp_err_o, wbif.rsp_dat_o}),
                64'({1'b1, exp_err, exp_dat}));
            chk({tag, " resp no accept"}, 64'({wbif.cmd_ready_o, wbif.wbm_cyc_o}), 64'b00);
        end
        wbif.wbm_ack_i   = 1'b0;
        wbif.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wbif.rsp_ready_i = 1'b0;
        chk({tag, " rsp released"}, 64'({wbif.rsp_valid_o, busy}), 64'b00);
        chk({tag, " back to idle"}, 64'(wbif.cmd_ready_o), 64'd1);
    endtask

    initial begin
        logic        r_we;
        logic [31:0] r_adr, r_dat, r_rdata, r_exp;
        logic [3:0]  r_sel;
        int          r_dly, r_wait, r_term;
        logic        r_err;

        n_cmp = 0;
        n_err = 0;
        rst              = 1'b1;
        wbif.cmd_valid_i = 1'b0;
        wbif.cmd_we_i    = 1'b0;
        wbif.cmd_adr_i   = '0;
        wbif.cmd_dat_i   = '0;
        wbif.cmd_sel_i   = '0;
        wbif.rsp_ready_i = 1'b0;
        wbif.wbm_dat_i   = '0;
        wbif.wbm_ack_i   = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset ready/valid/busy", 64'({wbif.cmd_ready_o, wbif.rsp_valid_o, busy}), 64'd0);
        chk("reset bus", 64'({wbif.wbm_cyc_o, wbif.wbm_stb_o, wbif.wbm_we_o,
                              wbif.wbm_sel_o, wbif.wbm_adr_o}), 64'd0);
        chk("reset dat", 64'({wbif.wbm_dat_o, wbif.rsp_dat_o}), 64'd0);
        chk("reset err", 64'(wbif.rsp_err_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post reset ready", 64'({wbif.cmd_ready_o, busy}), 64'b10);

        // Stray ack while idle must not produce anything.
        wbif.wbm_ack_i = 1'b1;
        wbif.wbm_dat_i = 32'h5555_AAAA;
        @(negedge clk);
        wbif.wbm_ack_i = 1'b0;
        chk("idle ack ignored", 64'({wbif.rsp_valid_o, busy, wbif.wbm_cyc_o}), 64'd0);

        vecs[0] = '{1'b1, 32'h2100_0004, 32'hDEAD_BEEF, 4'hF, 2, 0, 32'hCAFE_F00D, 32'h0, 1'b0, 3};
        vecs[1] = '{1'b0, 32'h2000_0000, 32'h0, 4'hF, 0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1};
        vecs[2] = '{1'b0, 32'h0000_0100, 32'h7, 4'h3, 1, 2, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0, 2};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0102_0304, 4'h1, 0, 1, 32'h9999_9999, 32'h0, 1'b0, 1};
        vecs[4] = '{1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 0, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0, 4};
`ifdef WB_HOST_MASTER_TIMEOUT_EN
        vecs[5] = '{1'b0, 32'h4000_0000, 32'h0, 4'hF, 40, 1, 32'h7777_1111, 32'h0, 1'b1, TO};
`else
        vecs[5] = '{1'b0, 32'h4000_0000, 32'h0, 4'hF, 40, 1, 32'h7777_1111, 32'h7777_1111, 1'b0, 41};
`endif
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].ack_dly,
                    vecs[i].rsp_wait, vecs[i].rdata, vecs[i].exp_dat, vecs[i].exp_err,
                    vecs[i].exp_cyc, 1'b0, $sformatf("vec%0d", i));
        end

        // Response back-pressure with a pending command behind it.
        run_txn(1'b0, 32'h5000_0000, 32'h0, 4'hF, 1, 10, 32'h1357_9BDF, 32'h1357_9BDF,
                1'b0, 2, 1'b1, "bp first");
        run_txn(1'b1, 32'h5000_0004, 32'h2468_ACE0, 4'hC, 0, 0, 32'h0, 32'h0,
                1'b0, 1, 1'b0, "bp second");

        for (int i = 0; i < 30; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_adr   = 32'($urandom);
            r_dat   = 32'($urandom);
            r_sel   = 4'($urandom);
            r_rdata = 32'($urandom);
            r_dly   = int'($urandom_range(0, 5));
            r_wait  = int'($urandom_range(0, 3));
            r_term  = r_dly + 1;
            r_err   = 1'b0;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
            if (r_term > TO) begin
                r_term = TO;
                r_err  = 1'b1;
            end
`endif
            r_exp = (r_err || r_we) ? 32'h0 : r_rdata;
            run_txn(r_we, r_adr, r_dat, r_sel, r_dly, r_wait, r_rdata, r_exp, r_err, r_term,
                    1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end
        wbif.cmd_valid_i = 1'b0;

        // Reset in the middle of a bus cycle.
        @(negedge clk);
        wbif.cmd_we_i    = 1'b0;
        wbif.cmd_adr_i   = 32'h6000_0000;
        wbif.cmd_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wbif.cmd_valid_i = 1'b0;
        chk("midbus cyc before reset", 64'(wbif.wbm_cyc_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midbus cyc/stb async drop", 64'({wbif.wbm_cyc_o, wbif.wbm_stb_o}), 64'b00);
        chk("midbus in reset", 64'({wbif.cmd_ready_o, wbif.rsp_valid_o, busy}), 64'b000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midbus after release", 64'({wbif.cmd_ready_o, wbif.rsp_valid_o, wbif.wbm_cyc_o}),
            64'b100);
        @(negedge clk);
        chk("midbus no response", 64'({wbif.rsp_valid_o, busy}), 64'b00);
        run_txn(1'b0, 32'h6000_0008, 32'h0, 4'hF, 0, 0, 32'hFEED_0001, 32'hFEED_0001,
                1'b0, 1, 1'b0, "recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_host_master.md
WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 SHALL have parameter DW, default 32, Wishbone data width (multiple of 8).
REQ-002 SHALL have parameter AW, default 32, Wishbone address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max bus cycles awaiting ack (1..65535).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: wb_clk_i input 1, rising-edge clock; wb_rst_i input 1, asynchronous active-high reset.
REQ-005 cmd_valid_i  input  1  command request; cmd_ready_o  output  1  command accepted when both high.
REQ-006 cmd_we_i  input  1  1=write, 0=read; cmd_adr_i  input  AW  byte address; cmd_dat_i  input  DW  write data; cmd_sel_i  input  DW/8  byte selects.
REQ-007 rsp_valid_o  output  1  response ready; rsp_ready_i  input  1  response consumed; rsp_dat_o  output  DW  read data; rsp_err_o  output  1  timeout flag.
REQ-008 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each; wbm_adr_o  output  AW; wbm_dat_o  output  DW; wbm_sel_o  output  DW/8; wbm_dat_i  input  DW; wbm_ack_i  input  1.
REQ-009 busy_o  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE, one Wishbone classic single transfer per command, no pipelining.
REQ-011 IDLE: cmd_ready_o=1; on cmd_valid_i&cmd_ready_o at edge N, register we/adr/dat/sel onto wbm_* and enter BUS; wbm_cyc_o=wbm_stb_o=1 from after edge N.
REQ-012 BUS: cmd_ready_o=0; wbm_* outputs held constant until termination.
REQ-013 BUS, wbm_ack_i high at edge M: capture wbm_dat_i into rsp_dat_o for reads (0 for writes), rsp_err_o=0, drop cyc/stb after edge M, enter RESP with rsp_valid_o=1.
REQ-014 Minimum latency cmd accept to rsp_valid_o: 2 cycles (ack in first BUS cycle).
REQ-015 RESP: rsp_valid_o, rsp_dat_o, rsp_err_o held stable until rsp_ready_i sampled high, then IDLE; no new command accepted in RESP.
REQ-016 wbm_ack_i SHALL be ignored in IDLE and RESP.
REQ-017 wbm_dat_o, wbm_sel_o, wbm_we_o SHALL be 0 when wbm_cyc_o=0.

Reset
REQ-018 wb_rst_i high SHALL asynchronously force IDLE, all outputs 0 except cmd_ready_o=0 while reset asserted, then cmd_ready_o=1 first cycle after release.
REQ-019 Reset mid-BUS SHALL drop wbm_cyc_o/wbm_stb_o immediately; the in-flight command is discarded with no response.

Configuration
REQ-020 Macro WB_HOST_MASTER_TIMEOUT_EN defined: BUS-cycle counter starts at 0 on BUS entry; if no ack by TIMEOUT BUS cycles, drop cyc/stb, enter RESP with rsp_err_o=1, rsp_dat_o=0.
REQ-021 Ack and timeout in the same cycle: ack wins, rsp_err_o=0.
REQ-022 Macro undefined: no counter instantiated, BUS waits indefinitely, rsp_err_o tied 0.

Structure
REQ-023 Package wb_host_master_pkg SHALL hold FSM state encoding (IDLE=0, BUS=1, RESP=2) and default DW/AW/TIMEOUT constants.
REQ-024 Timeout counter SHALL be sub-module wb_host_master_timer (clear, enable, expired), instantiated only under WB_HOST_MASTER_TIMEOUT_EN.

Verification
REQ-025 Write adr=0x2100_0004, dat=0xDEAD_BEEF, sel=0xF, ack after 2 cycles -> wbm_we_o=1, outputs stable 2 cycles, rsp_valid_o=1, rsp_err_o=0, rsp_dat_o=0.
REQ-026 Read adr=0x2000_0000, ack in first BUS cycle with wbm_dat_i=0x1234_5678 -> rsp_dat_o=0x1234_5678 2 cycles after accept.
REQ-027 Timeout enabled, TIMEOUT=4, no ack -> cyc/stb drop after 4 BUS cycles, rsp_err_o=1, rsp_dat_o=0.
REQ-028 Ack coincident with cycle 4 of TIMEOUT=4 -> rsp_err_o=0, read data returned.
REQ-029 rsp_ready_i held low 10 cycles with cmd_valid_i high -> rsp held, cmd_ready_o=0, second command accepted only after rsp_ready_i.
REQ-030 wb_rst_i asserted mid-BUS -> wbm_cyc_o=0 same cycle, no rsp_valid_o, cmd_ready_o=1 after release.
